xc_mp_alu: RTL
==============

Name: xc_mp_alu

Overview:
- Execute-stage datapath for the XCrypto multi-precision instructions: xc.madd.3, xc.msub.3, xc.macc.1 and xc.mmul.3.
- Produces the 64-bit destination register-pair result (lo/hi) that writeback commits and that the RVFI trace reports as rd_wdata/rd_wdatahi.
- Add/subtract ops complete in the request cycle. Multiply is iterative and multi-cycle.

Parameters:
- MUL_BITS, default 2, multiplier bits retired per cycle. Legal values: 1, 2, 4. Multiply iteration count N_ITER = 32/MUL_BITS.

Ports:
- g_clk  in  1  core clock, rising edge
- g_resetn  in  1  reset, synchronous, active-low
- valid  in  1  request valid; held high with operands stable until ready or flush
- flush  in  1  abort any in-flight op
- op_madd  in  1  select xc.madd.3
- op_msub  in  1  select xc.msub.3
- op_macc  in  1  select xc.macc.1
- op_mmul  in  1  select xc.mmul.3
- rs1  in  32  operand 1
- rs2  in  32  operand 2
- rs3  in  32  operand 3
- ready  out  1  result valid this cycle; single-cycle pulse per request
- result_lo  out  32  even-register result
- result_hi  out  32  odd-register result

Behaviour:
- Reset (g_resetn=0 at clock edge): state IDLE, counter 0, accumulator 0. Outputs ready=0, result_lo=0, result_hi=0.
- Whenever ready=0: result_lo and result_hi are driven 0.
- Op selects are one-hot. If more than one is set, priority is mmul > macc > msub > madd. If valid is high with no op set, ready is asserted with a zero result.
- Arithmetic, all unsigned, with R a 64-bit value, result_lo = R[31:0]:
  - madd: R = rs1 + rs2 + rs3[0]; result_hi = {31'b0, R[32]}.
  - msub: R = (rs1 - rs2) - rs3[0], computed mod 2^64; result_hi = {31'b0, R[32]}. R[32] is the borrow.
  - macc: R = {rs2, rs1} + {32'b0, rs3}, mod 2^64; result_hi = R[63:32].
  - mmul: R = rs1*rs2 + rs3. This never overflows 64 bits. result_hi = R[63:32].
- madd, msub, macc: combinational. ready=1 in the same cycle as valid while state is IDLE and flush=0. No state change.
- FSM states: IDLE, MUL, DONE.
  - IDLE -> MUL when valid & op_mmul & !flush. On this edge: acc <= {32'b0, rs3}, counter <= 0, the multiplier copy of rs1 is latched, ready stays 0.
  - MUL: each cycle acc += (rs1 * rs2[counter*MUL_BITS +: MUL_BITS]) << (counter*MUL_BITS), then counter++.
  - MUL -> DONE after the final iteration (counter == N_ITER-1).
  - DONE: ready=1 and results come from the registered acc. Always returns to IDLE next cycle.
- Multiply latency: ready asserted N_ITER+1 cycles after the valid cycle (17 cycles for MUL_BITS=2).
- flush=1 in any state: next state IDLE, ready=0 that cycle, no result. A flush in DONE suppresses ready.
- valid dropping during MUL or DONE is an abort, identical to flush.
- A new request may be accepted in the cycle after DONE. No back-to-back overlap.
- Operands are sampled once at IDLE->MUL, except rs2, which is read every cycle. rs2 must therefore stay stable; this is a protocol requirement.
- Counter width is log2(N_ITER). It never wraps because the FSM leaves MUL at N_ITER-1.

Decomposition:
- Shared package/header holds:
  - op encoding constants
  - FSM state encoding (IDLE=2'd0, MUL=2'd1, DONE=2'd2)
  - XLEN=32
  - the N_ITER derivation
- Sub-module xc_mp_mul_step: purely combinational, one partial-product accumulate step. Inputs: acc, rs1, the rs2 slice, counter. Output: acc_next. It is instanced once and unit-testable separately.

Test Plan:
- madd: rs1=0xFFFFFFFF, rs2=1, rs3=1 -> same-cycle ready, lo=0x00000001, hi=0x00000001.
- msub: rs1=5, rs2=7, rs3=1 -> same-cycle ready, lo=0xFFFFFFFD, hi=0x00000001. Second case: rs1=7, rs2=5, rs3=0 -> lo=2, hi=0.
- macc: rs1=0xFFFFFFFF, rs2=1, rs3=1 -> lo=0x00000000, hi=0x00000002.
- mmul (MUL_BITS=2): rs1=rs2=rs3=0xFFFFFFFF -> ready exactly 17 cycles after the valid cycle, lo=0x00000000, hi=0xFFFFFFFF. Repeat at MUL_BITS=1 and 4 with latencies 33 and 9.
- Abort: mmul 3x4+5 with flush pulsed on the 5th MUL cycle -> no ready. A madd issued the next cycle (1+2+1) returns lo=4, hi=0 in the same cycle.
- Reset mid-op: g_resetn=0 for one cycle during MUL -> ready=0 and results 0 the following cycle. A fresh mmul 0x10000*0x10000+0 then returns lo=0, hi=1.

Source files
------------

// File: rtl/xc_mp_alu_pkg.sv
// Shared definitions for the XCrypto multi-precision ALU: op encoding,
// FSM state encoding and multiply iteration count.
package xc_mp_alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MADD = 3'd1,
        OP_MSUB = 3'd2,
        OP_MACC = 3'd3,
        OP_MMUL = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int n_iter(input int mul_bits);
        return XLEN / mul_bits;
    endfunction

    // Selects are nominally one-hot; overlaps resolve mmul > macc > msub > madd.
    function automatic op_e op_decode(input logic madd, input logic msub,
                                      input logic macc, input logic mmul);
        if (mmul)      return OP_MMUL;
        else if (macc) return OP_MACC;
        else if (msub) return OP_MSUB;
        else if (madd) return OP_MADD;
        else           return OP_NONE;
    endfunction

endpackage

// File: rtl/xc_mp_mul_step.sv
// One shift-add multiply step: folds rs1 * (MUL_BITS-wide slice of rs2),
// aligned to the slice position, into the 64-bit accumulator.
module xc_mp_mul_step
    import xc_mp_alu_pkg::*;
#(
    parameter int MUL_BITS = 2,
    parameter int CNT_W    = 4
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   rs1,
    input  logic [MUL_BITS-1:0] rs2_slice,
    input  logic [CNT_W-1:0]  counter,
    output logic [2*XLEN-1:0] acc_next
);

    logic [5:0]        shamt;
    logic [2*XLEN-1:0] pp;

    always_comb begin
        shamt    = 6'(32'(counter) * MUL_BITS);
        pp       = (64'(rs1) * 64'(rs2_slice)) << shamt;
        acc_next = acc + pp;
    end

endmodule

// File: rtl/xc_mp_alu.sv
// Execute-stage datapath for xc.madd.3 / xc.msub.3 / xc.macc.1 (single cycle)
// and xc.mmul.3 (iterative, N_ITER+1 cycles of latency).
module xc_mp_alu
    import xc_mp_alu_pkg::*;
#(
    parameter int MUL_BITS = 2
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            valid,
    input  logic            flush,
    input  logic            op_madd,
    input  logic            op_msub,
    input  logic            op_macc,
    input  logic            op_mmul,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rs3,
    output logic            ready,
    output logic [XLEN-1:0] result_lo,
    output logic [XLEN-1:0] result_hi
);

    localparam int N_ITER = n_iter(MUL_BITS);
    localparam int CNT_W  = $clog2(N_ITER);

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   acc_next;
    logic [XLEN-1:0]     rs1_q;
    logic [4:0]          bit_idx;
    logic [MUL_BITS-1:0] rs2_slice;
    op_e                 op;
    logic [XLEN:0]       sum;
    logic [XLEN:0]       diff;
    logic [2*XLEN-1:0]   mac;

    // rs2 is not captured; the requester holds it stable for the whole op.
    assign bit_idx   = 5'(32'(cnt) * MUL_BITS);
    assign rs2_slice = rs2[bit_idx +: MUL_BITS];

    xc_mp_mul_step #(
        .MUL_BITS (MUL_BITS),
        .CNT_W    (CNT_W)
    ) u_mul_step (
        .acc       (acc),
        .rs1       (rs1_q),
        .rs2_slice (rs2_slice),
        .counter   (cnt),
        .acc_next  (acc_next)
    );

    always_comb begin
        op        = op_decode(op_madd, op_msub, op_macc, op_mmul);
        sum       = {1'b0, rs1} + {1'b0, rs2} + 33'(rs3[0]);
        diff      = {1'b0, rs1} - {1'b0, rs2} - 33'(rs3[0]);
        mac       = {rs2, rs1} + 64'(rs3);
        ready     = 1'b0;
        result_lo = '0;
        result_hi = '0;
        if (g_resetn && valid && !flush) begin
            if (state == IDLE) begin
                ready = (op != OP_MMUL);
                case (op)
                    OP_MADD: begin
                        result_lo = sum[XLEN-1:0];
                        result_hi = {31'b0, sum[XLEN]};
                    end
                    OP_MSUB: begin
                        result_lo = diff[XLEN-1:0];
                        result_hi = {31'b0, diff[XLEN]};
                    end
                    OP_MACC: begin
                        result_lo = mac[XLEN-1:0];
                        result_hi = mac[2*XLEN-1:XLEN];
                    end
                    default: ;
                endcase
            end else if (state == DONE) begin
                ready     = 1'b1;
                result_lo = acc[XLEN-1:0];
                result_hi = acc[2*XLEN-1:XLEN];
            end
        end
    end

    // Dropping valid mid-multiply is treated exactly like a flush.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            rs1_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid && !flush && op == OP_MMUL) begin
                        state <= MUL;
                        acc   <= 64'(rs3);
                        cnt   <= '0;
                        rs1_q <= rs1;
                    end
                end
                MUL: begin
                    if (flush || !valid) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(N_ITER - 1))
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
